// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per cycle through a shared 1-bit add cell.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' input selecting op_a - op_b (two's complement) instead of op_a + op_b.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic             accept_c, last_bit_c;
  logic             s1_c, c1_c, sum_bit_c, c2_c, carry_nxt_c;
  logic             sub_c;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_c = sub;
`else
  assign sub_c = 1'b0;
`endif

  // Two half-adder stages plus an OR form the shared full-adder cell
  assign s1_c        = a_q[0] ^ b_q[0];
  assign c1_c        = a_q[0] & b_q[0];
  assign sum_bit_c   = s1_c ^ carry_q;
  assign c2_c        = s1_c & carry_q;
  assign carry_nxt_c = c1_c | c2_c;

  assign last_bit_c  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (last_bit_c) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/result shifters, carry and bit counter; result/carry_out move only in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept_c) begin
      a_q     <= op_a;
      b_q     <= op_b ^ {WIDTH{sub_c}};
      carry_q <= sub_c;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= {sum_bit_c, res_q[WIDTH-1:1]};
      carry_q <= carry_nxt_c;
      cout_q  <= carry_nxt_c;
      if (!last_bit_c) cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = res_q;
  assign carry_out = cout_q;

endmodule
